dcu_deframer: RTL and testbench



---
 rtl/dcu_deframer.sv | 149 ++++++++++++++
 tb/tb_dcu_deframer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dcu_deframer.sv
// dcu_deframer: splits the merged DCU sample stream back into SIGNAL and PAYLOAD fields.
// Define DEFRAMER_ERR_CHECK_EN to build the truncated/overlong frame error checks.
module dcu_deframer #(
    parameter int DW      = 12,
    parameter int SIG_LEN = 480,
    parameter int SYM_LEN = 48,
    parameter int MAX_SYM = 50
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          new_frame,
    input  logic [DW-1:0] di_re,
    input  logic [DW-1:0] di_im,
    input  logic          di_vld,
    input  logic          di_last,
    output logic [DW-1:0] signal_do_re,
    output logic [DW-1:0] signal_do_im,
    output logic          signal_do_vld,
    output logic [DW-1:0] payload_do_re,
    output logic [DW-1:0] payload_do_im,
    output logic          payload_do_vld,
    output logic          payload_do_sym_end,
    output logic [3:0]    payload_do_num,
    output logic          frame_done,
    output logic          err_frame
);
    localparam int SGW = $clog2(SIG_LEN + 1);
    localparam int SBW = $clog2(SYM_LEN + 1);
    localparam int SMW = $clog2(MAX_SYM + 1);
    localparam logic [SGW-1:0] SIG_TOP = SGW'(SIG_LEN - 1);
    localparam logic [SBW-1:0] SUB_TOP = SBW'(SYM_LEN - 1);
    localparam logic [SMW-1:0] SYM_TOP = SMW'(MAX_SYM - 1);

    typedef enum logic [1:0] {IDLE, SIG, PLD} state_t;

    state_t         state, state_nx;
    logic [SGW-1:0] sig_cnt, sig_cnt_nx;
    logic [SBW-1:0] sub_cnt, sub_cnt_nx;
    logic [SMW-1:0] sym_cnt, sym_cnt_nx;

    logic       acc, sig_sel, pld_sel, at_sym_end, sym_full;
    logic       sym_end_d, done_d, err_d;
    logic [3:0] num_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sig_cnt <= '0;
            sub_cnt <= '0;
            sym_cnt <= '0;
        end else begin
            state   <= state_nx;
            sig_cnt <= sig_cnt_nx;
            sub_cnt <= sub_cnt_nx;
            sym_cnt <= sym_cnt_nx;
        end
    end

    // Output decode: routing and frame markers for the sample accepted this cycle.
    always_comb begin
        acc        = di_vld && !new_frame;
        sig_sel    = acc && (state != PLD);
        pld_sel    = acc && (state == PLD);
        at_sym_end = (sub_cnt == SUB_TOP);
        sym_full   = (sym_cnt == SYM_TOP);
`ifdef DEFRAMER_ERR_CHECK_EN
        err_d = (sig_sel && di_last) ||
                (pld_sel && di_last && !at_sym_end) ||
                (pld_sel && at_sym_end && sym_full && !di_last);
`else
        err_d = 1'b0;
`endif
        sym_end_d = pld_sel && (at_sym_end || err_d);
        done_d    = (pld_sel && at_sym_end && (di_last || sym_full)) || err_d;
        // In SIG no symbol is under way, so the count is just the completed ones (zero).
        num_d     = pld_sel ? 4'(sym_cnt + SMW'(1)) : 4'(sym_cnt);
    end

    always_comb begin
        state_nx   = state;
        sig_cnt_nx = sig_cnt;
        sub_cnt_nx = sub_cnt;
        sym_cnt_nx = sym_cnt;
        if (new_frame || (acc && done_d)) begin
            state_nx   = IDLE;
            sig_cnt_nx = '0;
            sub_cnt_nx = '0;
            sym_cnt_nx = '0;
        end else if (acc) begin
            case (state)
                IDLE, SIG: begin
                    if (sig_cnt == SIG_TOP) begin
                        state_nx   = PLD;
                        sig_cnt_nx = '0;
                    end else begin
                        state_nx   = SIG;
                        sig_cnt_nx = sig_cnt + 1'b1;
                    end
                end
                PLD: begin
                    if (at_sym_end) begin
                        sub_cnt_nx = '0;
                        sym_cnt_nx = sym_cnt + 1'b1;
                    end else begin
                        sub_cnt_nx = sub_cnt + 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signal_do_re       <= '0;
            signal_do_im       <= '0;
            signal_do_vld      <= 1'b0;
            payload_do_re      <= '0;
            payload_do_im      <= '0;
            payload_do_vld     <= 1'b0;
            payload_do_sym_end <= 1'b0;
            payload_do_num     <= '0;
            frame_done         <= 1'b0;
        end else begin
            signal_do_vld      <= sig_sel;
            payload_do_vld     <= pld_sel;
            payload_do_sym_end <= sym_end_d;
            frame_done         <= done_d;
            if (sig_sel) begin
                signal_do_re <= di_re;
                signal_do_im <= di_im;
            end
            if (pld_sel) begin
                payload_do_re <= di_re;
                payload_do_im <= di_im;
            end
            if (done_d) payload_do_num <= num_d;
        end
    end

`ifdef DEFRAMER_ERR_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_frame <= 1'b0;
        else        err_frame <= err_d;
    end
`else
    assign err_frame = 1'b0;
`endif
endmodule

// File: tb/tb_dcu_deframer.sv
// Randomized bench for dcu_deframer: frame-position model plus per-scenario literal counts.
module tb_dcu_deframer;
    localparam int DW = 12, SIG_LEN = 480, SYM_LEN = 48, MAX_SYM = 50;
`ifdef DEFRAMER_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, new_frame = 1'b0, di_vld = 1'b0, di_last = 1'b0;
    logic [DW-1:0] di_re = '0, di_im = '0;
    logic [DW-1:0] signal_do_re, signal_do_im, payload_do_re, payload_do_im;
    logic signal_do_vld, payload_do_vld, payload_do_sym_end, frame_done, err_frame;
    logic [3:0] payload_do_num;

    dcu_deframer #(.DW(DW), .SIG_LEN(SIG_LEN), .SYM_LEN(SYM_LEN), .MAX_SYM(MAX_SYM)) dut (
        .clk(clk), .rst_n(rst_n), .new_frame(new_frame),
        .di_re(di_re), .di_im(di_im), .di_vld(di_vld), .di_last(di_last),
        .signal_do_re(signal_do_re), .signal_do_im(signal_do_im), .signal_do_vld(signal_do_vld),
        .payload_do_re(payload_do_re), .payload_do_im(payload_do_im), .payload_do_vld(payload_do_vld),
        .payload_do_sym_end(payload_do_sym_end), .payload_do_num(payload_do_num),
        .frame_done(frame_done), .err_frame(err_frame)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is a sample index; index < SIG_LEN is SIGNAL, the rest is payload.
    bit in_frame = 0;
    int idx = 0;
    logic e_svld = 0, e_pvld = 0, e_se = 0, e_done = 0, e_err = 0;
    logic [DW-1:0] e_sre = '0, e_sim = '0, e_pre = '0, e_pim = '0;
    logic [3:0] e_num = '0;

    always @(posedge clk or negedge rst_n) begin
        int p, nsym;
        bit se, full;
        if (!rst_n) begin
            in_frame = 0; idx = 0;
            e_svld = 0; e_pvld = 0; e_se = 0; e_done = 0; e_err = 0;
            e_sre = '0; e_sim = '0; e_pre = '0; e_pim = '0; e_num = '0;
        end else begin
            e_svld = 0; e_pvld = 0; e_se = 0; e_done = 0; e_err = 0;
            if (new_frame) begin
                in_frame = 0; idx = 0;
            end else if (di_vld) begin
                if (!in_frame) begin in_frame = 1; idx = 0; end
                if (idx < SIG_LEN) begin
                    e_svld = 1; e_sre = di_re; e_sim = di_im;
                    if (ERR_EN && di_last) begin e_err = 1; e_done = 1; e_num = 4'd0; end
                end else begin
                    p = idx - SIG_LEN;
                    se = (p % SYM_LEN) == SYM_LEN - 1;
                    nsym = p / SYM_LEN + 1;
                    full = (nsym == MAX_SYM);
                    e_pvld = 1; e_pre = di_re; e_pim = di_im;
                    if (ERR_EN) e_err = (di_last && !se) || (se && full && !di_last);
                    e_se = se || e_err;
                    e_done = (se && (di_last || full)) || e_err;
                    if (e_done) e_num = 4'(nsym % 16);
                end
                if (e_done) in_frame = 0; else idx++;
            end
        end
    end

    int n_sig = 0, n_pld = 0, n_se = 0, n_done = 0, n_err = 0;
    logic [3:0] last_num = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("signal_vld", signal_do_vld, e_svld);
            chk("payload_vld", payload_do_vld, e_pvld);
            chk("sym_end", payload_do_sym_end, e_se);
            chk("frame_done", frame_done, e_done);
            chk("err_frame", err_frame, e_err);
            chk("signal_data", {signal_do_re, signal_do_im}, {e_sre, e_sim});
            chk("payload_data", {payload_do_re, payload_do_im}, {e_pre, e_pim});
            if (e_done) chk("payload_num", payload_do_num, e_num);
            n_sig  += int'(signal_do_vld);
            n_pld  += int'(payload_do_vld);
            n_se   += int'(payload_do_sym_end);
            n_done += int'(frame_done);
            n_err  += int'(err_frame);
            if (frame_done) last_num = payload_do_num;
        end
    end

    int b_sig, b_pld, b_se, b_done, b_err;

    task automatic mark();
        b_sig = n_sig; b_pld = n_pld; b_se = n_se; b_done = n_done; b_err = n_err;
    endtask

    task automatic expect_counts(input string tag, input int s, input int p, input int se,
                                 input int d, input int e, input int num);
        repeat (2) @(negedge clk);
        chk({tag, "_sig_cnt"}, n_sig - b_sig, s);
        chk({tag, "_pld_cnt"}, n_pld - b_pld, p);
        chk({tag, "_sym_end_cnt"}, n_se - b_se, se);
        chk({tag, "_done_cnt"}, n_done - b_done, d);
        chk({tag, "_err_cnt"}, n_err - b_err, e);
        if (num >= 0) chk({tag, "_num"}, last_num, num);
    endtask

    // gap < 0 picks a random idle gap of 0..3 cycles.
    task automatic drive(input bit last, input int gap);
        int g;
        di_vld = 1'b1; di_last = last;
        di_re = DW'($urandom); di_im = DW'($urandom);
        @(negedge clk);
        di_vld = 1'b0; di_last = 1'b0;
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        repeat (g) @(negedge clk);
    endtask

    task automatic send(input int n, input int gs, input int gp, input int la, input int lb);
        for (int i = 0; i < n; i++)
            drive((i == la) || (i == lb), (i < SIG_LEN) ? gs : gp);
    endtask

    task automatic pulse_new_frame(input bit with_vld);
        new_frame = 1'b1; di_vld = with_vld; di_re = DW'($urandom);
        @(negedge clk);
        new_frame = 1'b0; di_vld = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_signal_vld", signal_do_vld, 0);
        chk("reset_payload_vld", payload_do_vld, 0);
        chk("reset_done", frame_done, 0);
        chk("reset_num", payload_do_num, 0);
        rst_n = 1'b1;
        @(negedge clk);

        mark(); send(2880, 0, 0, 2879, -1);
        expect_counts("nominal", 480, 2400, 50, 1, 0, 2);

        mark(); send(2880, 1, 3, 2879, -1);
        expect_counts("gapped", 480, 2400, 50, 1, 0, 2);

        mark(); send(581, 0, 0, -1, -1); pulse_new_frame(1'b1);
        send(720, 0, 0, 719, -1);
        expect_counts("abort", 960, 341, 7, 1, 0, 5);

        mark(); send(528, 0, 0, 527, -1); send(528, 0, 0, 527, -1);
        expect_counts("b2b", 960, 96, 2, 2, 0, 1);

        mark();
        if (ERR_EN) begin
            send(511, 0, 0, 510, -1);
            expect_counts("early_last", 480, 31, 1, 1, 1, 1);
        end else begin
            send(528, 0, 0, 510, 527);
            expect_counts("early_last", 480, 48, 1, 1, 0, 1);
        end

        mark(); send(2890, 0, 0, -1, -1); pulse_new_frame(1'b0);
        expect_counts("max_sym", 490, 2400, 50, 1, ERR_EN ? 1 : 0, 2);

        send(100, 0, 0, -1, -1);
        di_vld = 1'b1; di_re = DW'($urandom);
        @(posedge clk); #2 rst_n = 1'b0; #1;
        chk("async_rst_signal_vld", signal_do_vld, 0);
        chk("async_rst_signal_re", signal_do_re, 0);
        chk("async_rst_payload_vld", payload_do_vld, 0);
        @(negedge clk); di_vld = 1'b0; rst_n = 1'b1; @(negedge clk);
        mark(); send(528, 0, 0, 527, -1);
        expect_counts("after_rst", 480, 48, 1, 1, 0, 1);

        for (int f = 0; f < 6; f++) begin
            int n;
            n = SIG_LEN + SYM_LEN * int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++)
                drive((i == n - 1) || ($urandom_range(0, 49) == 0), -1);
        end
        pulse_new_frame(1'b0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
